seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter SYM_W, default 2, bits per input symbol.
REQ-002 SHALL have parameter MAX_LEN, default 8, maximum pattern length in symbols (>=2).
REQ-003 SHALL have parameter CNT_W, default 8, match counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port sym_vld  input  1  sym carries a valid symbol this cycle.
REQ-007 SHALL have port sym  input  SYM_W  serial data symbol.
REQ-008 SHALL have port cfg_we  input  1  write cfg_sym into pattern entry cfg_idx.
REQ-009 SHALL have port cfg_idx  input  $clog2(MAX_LEN)  pattern entry index; 0 = first symbol of sequence.
REQ-010 SHALL have port cfg_sym  input  SYM_W  pattern symbol value.
REQ-011 SHALL have port len_we  input  1  load cfg_len into the active length register.
REQ-012 SHALL have port cfg_len  input  $clog2(MAX_LEN+1)  pattern length; values >MAX_LEN clamp to MAX_LEN.
REQ-013 SHALL have port ovl_en  input  1  1 = overlapping matches allowed, 0 = history restarts after each match.
REQ-014 SHALL have port match  output  1  one-cycle pulse per detected sequence.
REQ-015 SHALL have port state_o  output  2  current FSM state.

Function
REQ-016 SHALL keep a history of the last MAX_LEN accepted symbols plus a fill count saturating at MAX_LEN.
REQ-017 SHALL accept a symbol only when sym_vld=1, cfg_we=0 and len_we=0; a symbol arriving with a config write is dropped.
REQ-018 SHALL declare a match when an accepted symbol makes the newest len symbols equal pat[0..len-1] in arrival order.
REQ-019 SHALL assert match registered, exactly one cycle after the clk edge that accepts the completing symbol, for one cycle.
REQ-020 SHALL, with ovl_en=1, keep history after a match (pattern 1,1 on input 1,1,1 gives two pulses).
REQ-021 SHALL, with ovl_en=0, clear fill count on a match so the next match needs len fresh symbols.
REQ-022 SHALL clear fill count on any cfg_we or len_we; pattern storage changes only on cfg_we.
REQ-023 SHALL never assert match while len=0.
REQ-024 SHALL run an FSM: S_IDLE (len=0), S_FILL (fill < len-1), S_ARMED (fill >= len-1, next accepted symbol can match).
REQ-025 SHALL transition S_IDLE->S_FILL on len_we with cfg_len>=2; S_IDLE->S_ARMED on len_we with cfg_len=1; any->S_IDLE on len_we with cfg_len=0.
REQ-026 SHALL transition S_FILL->S_ARMED when fill reaches len-1; S_ARMED->S_FILL on match with ovl_en=0 (len>=2) or on any config write.
REQ-027 SHALL hold state when sym_vld=0; gaps in sym_vld do not break a sequence.

Reset
REQ-028 SHALL on clr=1 set match=0, fill=0, len=0, state S_IDLE, all pattern entries 0, match_cnt=0.
REQ-029 SHALL give clr priority over every other input in the same cycle, including a completing symbol.

Configuration
REQ-030 SHALL, when SEQ_DET_CNT_EN is defined, add ports match_cnt (output, CNT_W, saturating count of match pulses) and cnt_clr (input, 1, synchronous clear, wins over a same-cycle increment).
REQ-031 SHALL, when SEQ_DET_CNT_EN is undefined, omit match_cnt, cnt_clr and counter logic; other behaviour unchanged.

Structure
REQ-032 SHALL place the FSM state enum (S_IDLE=0, S_FILL=1, S_ARMED=2) and default parameter constants in package seq_det_pkg.
REQ-033 SHALL implement the history-versus-pattern compare in sub-module seq_det_cmp (combinational, length-masked equality).

Verification
REQ-034 SHALL cover: pattern 3,3,2 len 3, input 1,3,3,2 -> match one cycle after the 2 is accepted, once.
REQ-035 SHALL cover: pattern 1,1 len 2, input 1,1,1 -> two pulses with ovl_en=1, one pulse with ovl_en=0.
REQ-036 SHALL cover: pattern 3,3,2, input 3,3 then cfg_we, then 2 -> no match; sym_vld with cfg_we dropped.
REQ-037 SHALL cover: len=0, random 200 symbols -> match stays 0, state_o=S_IDLE.
REQ-038 SHALL cover: SEQ_DET_CNT_EN, CNT_W=2, five matches -> match_cnt=3; cnt_clr -> 0.
REQ-039 SHALL cover: clr asserted in the cycle of a completing symbol -> no match, all outputs at reset values next cycle.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared FSM encoding and default sizing for the serial sequence detector.
package seq_det_pkg;

   localparam int SYM_W_D   = 2;
   localparam int MAX_LEN_D = 8;
   localparam int CNT_W_D   = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_ARMED = 2'd2
   } state_t;

endpackage

// File: rtl/seq_det_cmp.sv
// Length-masked equality of a symbol window against the stored pattern.
// win[0] is the newest symbol; it lines up with pat[len-1].
module seq_det_cmp
   import seq_det_pkg::*;
#(
   parameter int SYM_W   = SYM_W_D,
   parameter int MAX_LEN = MAX_LEN_D,
   parameter int LEN_W   = $clog2(MAX_LEN_D + 1)
) (
   input  logic [MAX_LEN-1:0][SYM_W-1:0] win,
   input  logic [MAX_LEN-1:0][SYM_W-1:0] pat,
   input  logic [LEN_W-1:0]              len,
   output logic                          eq
);

   localparam int IDX_W = $clog2(MAX_LEN);

   logic [MAX_LEN-1:0] ok;

   for (genvar k = 0; k < MAX_LEN; k++) begin : g_ent
      logic [IDX_W-1:0] pidx;
      always_comb begin
         pidx  = IDX_W'(len - LEN_W'(k) - LEN_W'(1));
         ok[k] = 1'b1;
         // entries beyond the active length never block a match
         if (LEN_W'(k) < len)
            ok[k] = (win[k] == pat[pidx]);
      end
   end

   assign eq = &ok;

endmodule

// File: rtl/seq_detect_param.sv
// Configurable serial pattern detector with overlap control.
// Define SEQ_DET_CNT_EN to add the saturating match counter (match_cnt, cnt_clr).
module seq_detect_param
   import seq_det_pkg::*;
#(
   parameter int SYM_W   = SYM_W_D,
   parameter int MAX_LEN = MAX_LEN_D,
   parameter int CNT_W   = CNT_W_D
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic                         sym_vld,
   input  logic [SYM_W-1:0]             sym,
   input  logic                         cfg_we,
   input  logic [$clog2(MAX_LEN)-1:0]   cfg_idx,
   input  logic [SYM_W-1:0]             cfg_sym,
   input  logic                         len_we,
   input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
   input  logic                         ovl_en,
`ifdef SEQ_DET_CNT_EN
   input  logic                         cnt_clr,
   output logic [CNT_W-1:0]             match_cnt,
`endif
   output logic                         match,
   output logic [1:0]                   state_o
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic [MAX_LEN-1:0][SYM_W-1:0] hist, pat, win;
   logic [LEN_W-1:0] len, len_ld, fill, fill_n, fill_inc;
   state_t           state, state_n;
   logic             accept, cfg_any, eq, hit;

   assign cfg_any  = cfg_we | len_we;
   assign accept   = sym_vld & ~cfg_any;
   assign win      = {hist[MAX_LEN-2:0], sym};
   assign len_ld   = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
   assign fill_inc = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
   assign hit      = (state == S_ARMED) & accept & eq;
   assign state_o  = state;

   seq_det_cmp #(
      .SYM_W   (SYM_W),
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_cmp (
      .win (win),
      .pat (pat),
      .len (len),
      .eq  (eq)
   );

   always_comb begin
      state_n = state;
      fill_n  = fill;
      if (cfg_any)
         fill_n = '0;
      else if (accept)
         fill_n = (hit && !ovl_en) ? '0 : fill_inc;

      if (len_we) begin
         if (len_ld == '0)             state_n = S_IDLE;
         else if (len_ld == LEN_W'(1)) state_n = S_ARMED;
         else                          state_n = S_FILL;
      end else begin
         case (state)
            S_IDLE: ;
            S_FILL: begin
               if (cfg_we)
                  state_n = S_FILL;
               else if (accept && fill_inc >= len - 1'b1)
                  state_n = S_ARMED;
            end
            S_ARMED: begin
               // a length-1 pattern is armed even with an empty history
               if (len != LEN_W'(1) && (cfg_we || (hit && !ovl_en)))
                  state_n = S_FILL;
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= S_IDLE;
         fill  <= '0;
         len   <= '0;
         pat   <= '0;
         hist  <= '0;
         match <= 1'b0;
      end else begin
         state <= state_n;
         fill  <= fill_n;
         match <= hit;
         if (len_we)
            len <= len_ld;
         if (cfg_we && int'(cfg_idx) < MAX_LEN)
            pat[cfg_idx] <= cfg_sym;
         if (accept)
            hist <= win;
      end
   end

`ifdef SEQ_DET_CNT_EN
   // counts on the accepting edge so the count moves together with the pulse
   always_ff @(posedge clk) begin
      if (clr || cnt_clr)
         match_cnt <= '0;
      else if (hit && match_cnt != '1)
         match_cnt <= match_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomized and directed checks of seq_detect_param against a queue-based model.
module tb_seq_detect_param;

   localparam int SYM_W   = 2;
   localparam int MAX_LEN = 8;
`ifdef SEQ_DET_CNT_EN
   localparam int CNT_W   = 2;
`else
   localparam int CNT_W   = 8;
`endif

   logic                         clk = 1'b0;
   logic                         clr, sym_vld, cfg_we, len_we, ovl_en;
   logic [SYM_W-1:0]             sym, cfg_sym;
   logic [$clog2(MAX_LEN)-1:0]   cfg_idx;
   logic [$clog2(MAX_LEN+1)-1:0] cfg_len;
   logic                         match;
   logic [1:0]                   state_o;
`ifdef SEQ_DET_CNT_EN
   logic                         cnt_clr;
   logic [CNT_W-1:0]             match_cnt;
`endif

   seq_detect_param #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .clr       (clr),
      .sym_vld   (sym_vld),
      .sym       (sym),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_sym   (cfg_sym),
      .len_we    (len_we),
      .cfg_len   (cfg_len),
      .ovl_en    (ovl_en),
`ifdef SEQ_DET_CNT_EN
      .cnt_clr   (cnt_clr),
      .match_cnt (match_cnt),
`endif
      .match     (match),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // reference: the accepted symbols since the last history reset
   int q[$];
   int pat[MAX_LEN];
   int mlen = 0;
   int e_match = 0;
   int e_cnt = 0;
   int npulse = 0;

   task automatic cyc(input string tag, input bit c, input bit v, input int s,
                      input bit cwe, input int idx, input int csym,
                      input bit lwe, input int clen, input bit cc);
      bit h;
      int est;
      clr = c; sym_vld = v; sym = SYM_W'(s);
      cfg_we = cwe; cfg_idx = 3'(idx); cfg_sym = SYM_W'(csym);
      len_we = lwe; cfg_len = 4'(clen);
`ifdef SEQ_DET_CNT_EN
      cnt_clr = cc;
`endif
      if (c) begin
         q.delete();
         foreach (pat[i]) pat[i] = 0;
         mlen = 0; e_match = 0; e_cnt = 0;
      end else begin
         e_match = 0;
         if (cwe || lwe) begin
            if (cwe) pat[idx] = csym;
            if (lwe) mlen = (clen > MAX_LEN) ? MAX_LEN : clen;
            q.delete();
         end else if (v) begin
            q.push_back(s);
            if (q.size() > MAX_LEN) void'(q.pop_front());
            if (mlen > 0 && q.size() >= mlen) begin
               h = 1;
               for (int k = 0; k < mlen; k++)
                  if (q[q.size() - mlen + k] != pat[k]) h = 0;
               if (h) begin
                  e_match = 1;
                  if (!ovl_en) q.delete();
               end
            end
         end
         if (cc) e_cnt = 0;
         else if (e_match != 0 && e_cnt < (1 << CNT_W) - 1) e_cnt++;
      end
      @(posedge clk); #1;
      est = (mlen == 0) ? 0 : ((q.size() >= mlen - 1) ? 2 : 1);
      chk({tag, ".match"}, int'(match), e_match);
      chk({tag, ".state"}, int'(state_o), est);
`ifdef SEQ_DET_CNT_EN
      chk({tag, ".cnt"}, int'(match_cnt), e_cnt);
`endif
      npulse += int'(match);
   endtask

   task automatic feed(input string tag, input int s);
      cyc(tag, 0, 1, s, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic idle(input string tag);
      cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic wpat(input int idx, input int v);
      cyc("wpat", 0, 0, 0, 1, idx, v, 0, 0, 0);
   endtask
   task automatic wlen(input int n);
      cyc("wlen", 0, 0, 0, 0, 0, 0, 1, n, 0);
   endtask

   initial begin
      clr = 0; sym_vld = 0; sym = '0; cfg_we = 0; cfg_idx = '0; cfg_sym = '0;
      len_we = 0; cfg_len = '0; ovl_en = 1;
`ifdef SEQ_DET_CNT_EN
      cnt_clr = 0;
`endif
      cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_match", int'(match), 0);
      chk("rst_state", int'(state_o), 0);

      // 3,3,2 found once in 1,3,3,2
      wpat(0, 3); wpat(1, 3); wpat(2, 2); wlen(3);
      npulse = 0;
      feed("d34", 1); feed("d34", 3); feed("d34", 3); feed("d34", 2); idle("d34");
      chk("d34_pulses", npulse, 1);

      // 1,1 on 1,1,1 with and without overlap
      wpat(0, 1); wpat(1, 1); wlen(2);
      ovl_en = 1; npulse = 0;
      feed("d35o", 1); feed("d35o", 1); feed("d35o", 1);
      chk("d35_ovl_pulses", npulse, 2);
      ovl_en = 0; wlen(2); npulse = 0;
      feed("d35n", 1); feed("d35n", 1); feed("d35n", 1);
      chk("d35_novl_pulses", npulse, 1);

      // config write mid-sequence drops the symbol and restarts history
      ovl_en = 1;
      wpat(0, 3); wpat(1, 3); wpat(2, 2); wlen(3);
      npulse = 0;
      feed("d36", 3); feed("d36", 3);
      cyc("d36_drop", 0, 1, 2, 1, 0, 3, 0, 0, 0);
      feed("d36", 2);
      chk("d36_pulses", npulse, 0);

      // length zero never matches and stays idle
      wlen(0); npulse = 0;
      for (int i = 0; i < 200; i++)
         cyc("d37", 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0, 0, 0, 0, 0, 0);
      chk("d37_pulses", npulse, 0);

      // clr on the completing symbol wins; pattern storage returns to zero
      wpat(0, 3); wpat(1, 3); wpat(2, 2); wlen(3);
      feed("d39", 3); feed("d39", 3);
      cyc("d39_clr", 1, 1, 2, 0, 0, 0, 0, 0, 0);
      chk("d39_match", int'(match), 0);
      chk("d39_state", int'(state_o), 0);
      wlen(3); npulse = 0;
      feed("d39z", 0); feed("d39z", 0); feed("d39z", 0);
      chk("d39_zero_pat", npulse, 1);

`ifdef SEQ_DET_CNT_EN
      // saturation at 3 with a 2-bit counter, then clear beating an increment
      cyc("cnt_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      wpat(0, 1); wlen(1); ovl_en = 1;
      for (int i = 0; i < 5; i++) feed("cnt", 1);
      chk("cnt_sat", int'(match_cnt), 3);
      cyc("cnt_clr", 0, 1, 1, 0, 0, 0, 0, 0, 1);
      chk("cnt_clr_wins", int'(match_cnt), 0);
`endif

      // random traffic with occasional reconfiguration and resets
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 4)
            wpat(int'($urandom_range(0, MAX_LEN - 1)), int'($urandom_range(0, 3)));
         else if (r < 6)
            wlen(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                              : int'($urandom_range(1, 3)));
         else if (r < 8) begin
            ovl_en = ~ovl_en;
            idle("rnd_ovl");
         end else if (r < 9)
            cyc("rnd_clr", 1, 1, int'($urandom_range(0, 3)), 0, 0, 0, 0, 0, 0);
         else
            cyc("rnd", 0, 1'($urandom_range(0, 4) != 0), int'($urandom_range(0, 3)),
                0, 0, 0, 0, 0, 1'($urandom_range(0, 49) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
